// File: rtl/aes_pkg.sv
// AES shared types, S-box and GF(2^8) helpers.
// Used by the iterative AES core and its round function.
package aes_pkg;

  typedef logic [0:15][7:0] state_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } fsm_t;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] xtime(
    input logic [7:0] b
  );
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul2(
    input logic [7:0] b
  );
    return xtime(b);
  endfunction

  function automatic logic [7:0] gmul3(
    input logic [7:0] b
  );
    return xtime(b) ^ b;
  endfunction

  function automatic int nr_of(input int kb);
    return (kb == 256) ? 14 : (kb == 192) ? 12 : 10;
  endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES encryption round.
// The final round skips MixColumns.
module aes_round
  import aes_pkg::*;
(
  input  state_t       s,
  input  logic [127:0] rk,
  input  logic         last,
  output state_t       q
);

  state_t sb;
  state_t sr;
  state_t mc;

  // SubBytes
  always_comb begin
    sb = '0;
    for (int i = 0; i < 16; i++) begin
      sb[i] = SBOX[s[i]];
    end
  end

  // ShiftRows: row r rotates left by r
  always_comb begin
    sr = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[r + 4*c] = sb[r + 4*((c + r) % 4)];
      end
    end
  end

  // MixColumns per column
  always_comb begin
    mc = '0;
    for (int c = 0; c < 4; c++) begin
      mc[4*c] = gmul2(sr[4*c]) ^ gmul3(sr[4*c+1])
              ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+1] = sr[4*c] ^ gmul2(sr[4*c+1])
                ^ gmul3(sr[4*c+2]) ^ sr[4*c+3];
      mc[4*c+2] = sr[4*c] ^ sr[4*c+1]
                ^ gmul2(sr[4*c+2]) ^ gmul3(sr[4*c+3]);
      mc[4*c+3] = gmul3(sr[4*c]) ^ sr[4*c+1]
                ^ sr[4*c+2] ^ gmul2(sr[4*c+3]);
    end
  end

  // AddRoundKey
  always_comb begin
    q = state_t'((last ? sr : mc) ^ rk);
  end

endmodule

// File: rtl/aes_iter_core.sv
// Folded AES encryption engine, ROUND_UNROLL rounds per clock.
// Valid/ready in and out, tag carried alongside each block.
module aes_iter_core
  import aes_pkg::*;
#(
  parameter int KEY_BITS     = 128,
  parameter int ROUND_UNROLL = 1,
  parameter int TAG_W        = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             valid_i,
  output logic                             ready_o,
  input  logic [127:0]                     plaintext_i,
  input  logic [TAG_W-1:0]                 tag_i,
  input  logic [nr_of(KEY_BITS):0][127:0]  round_key_i,
  output logic                             valid_o,
  input  logic                             ready_i,
  output logic [127:0]                     ciphertext_o,
  output logic [TAG_W-1:0]                 tag_o,
  output logic                             busy_o
);

  localparam int NR  = nr_of(KEY_BITS);
  localparam int CW  = $clog2(NR + 1);
  localparam int CW1 = CW + 1;

  if ((KEY_BITS != 128 && KEY_BITS != 192
       && KEY_BITS != 256)
      || ROUND_UNROLL < 1 || ROUND_UNROLL > 2
      || (NR % ROUND_UNROLL) != 0) begin : g_bad_cfg
    $error("aes_iter_core: bad KEY_BITS/ROUND_UNROLL");
  end

  fsm_t             state;
  fsm_t             nxt;
  logic             accept;
  logic             fin;
  state_t           st;
  logic [CW-1:0]    rnd;
  logic [TAG_W-1:0] tag_q;
  logic [CW:0]      rnd_end;
  state_t           chain [ROUND_UNROLL+1];

  assign chain[0] = st;

  for (genvar j = 0; j < ROUND_UNROLL; j++) begin : g_rnd
    logic [CW-1:0] idx;
    assign idx = rnd + CW'(j);
    aes_round u_round (
      .s    (chain[j]),
      .rk   (round_key_i[idx]),
      .last (idx == CW'(NR)),
      .q    (chain[j+1])
    );
  end

  assign rnd_end = {1'b0, rnd} + CW1'(ROUND_UNROLL - 1);
  assign fin     = (rnd_end == CW1'(NR));

  assign ready_o = (state == IDLE)
                 | ((state == DONE) & ready_i);
  assign valid_o = (state == DONE);
  assign busy_o  = (state != IDLE);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // next state and accept decode
  always_comb begin
    nxt    = state;
    accept = 1'b0;
    unique case (state)
      IDLE: begin
        if (valid_i) begin
          accept = 1'b1;
          nxt    = RUN;
        end
      end
      RUN: begin
        if (fin) nxt = DONE;
      end
      DONE: begin
        if (ready_i) begin
          accept = valid_i;
          nxt    = valid_i ? RUN : IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // round state, counter, tag and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st           <= '0;
      rnd          <= '0;
      tag_q        <= '0;
      ciphertext_o <= '0;
      tag_o        <= '0;
    end else if (accept) begin
      st    <= state_t'(plaintext_i ^ round_key_i[0]);
      rnd   <= CW'(1);
      tag_q <= tag_i;
    end else if (state == RUN) begin
      st  <= chain[ROUND_UNROLL];
      rnd <= rnd + CW'(ROUND_UNROLL);
      if (fin) begin
        ciphertext_o <= chain[ROUND_UNROLL];
        tag_o        <= tag_q;
      end
    end
  end

endmodule

// File: tb/tb_aes_iter_core.sv
// Known-answer and handshake bench for aes_iter_core.
// Four builds: AES-128, AES-192, AES-256, AES-128 two rounds/clk.
module tb_aes_iter_core;
  import aes_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic ready_i;
  logic [127:0] pt;
  logic [7:0] tag;

  logic vin [4];
  logic vout [4];
  logic rdy [4];
  logic bsy [4];
  logic [127:0] cto [4];
  logic [7:0] tgo [4];

  logic [10:0][127:0] rk128;
  logic [12:0][127:0] rk192;
  logic [14:0][127:0] rk256;
  logic [10:0][127:0] rk128u2;

  int total = 0;
  int pass = 0;

  always #5 clk = ~clk;

  aes_iter_core #(.KEY_BITS(128), .ROUND_UNROLL(1), .TAG_W(8)) d0 (
    .clk(clk), .rst_n(rst_n), .valid_i(vin[0]), .ready_o(rdy[0]),
    .plaintext_i(pt), .tag_i(tag), .round_key_i(rk128),
    .valid_o(vout[0]), .ready_i(ready_i), .ciphertext_o(cto[0]),
    .tag_o(tgo[0]), .busy_o(bsy[0]));

  aes_iter_core #(.KEY_BITS(192), .ROUND_UNROLL(1), .TAG_W(8)) d1 (
    .clk(clk), .rst_n(rst_n), .valid_i(vin[1]), .ready_o(rdy[1]),
    .plaintext_i(pt), .tag_i(tag), .round_key_i(rk192),
    .valid_o(vout[1]), .ready_i(ready_i), .ciphertext_o(cto[1]),
    .tag_o(tgo[1]), .busy_o(bsy[1]));

  aes_iter_core #(.KEY_BITS(256), .ROUND_UNROLL(1), .TAG_W(8)) d2 (
    .clk(clk), .rst_n(rst_n), .valid_i(vin[2]), .ready_o(rdy[2]),
    .plaintext_i(pt), .tag_i(tag), .round_key_i(rk256),
    .valid_o(vout[2]), .ready_i(ready_i), .ciphertext_o(cto[2]),
    .tag_o(tgo[2]), .busy_o(bsy[2]));

  aes_iter_core #(.KEY_BITS(128), .ROUND_UNROLL(2), .TAG_W(8)) d3 (
    .clk(clk), .rst_n(rst_n), .valid_i(vin[3]), .ready_o(rdy[3]),
    .plaintext_i(pt), .tag_i(tag), .round_key_i(rk128u2),
    .valid_o(vout[3]), .ready_i(ready_i), .ciphertext_o(cto[3]),
    .tag_o(tgo[3]), .busy_o(bsy[3]));

  task automatic chk(input string nm, input logic [159:0] act,
                     input logic [159:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {SBOX[t[31:24]], SBOX[t[23:16]],
            SBOX[t[15:8]], SBOX[t[7:0]]};
  endfunction

  // FIPS-197 key expansion; key is left-aligned in 256 bits
  function automatic logic [14:0][127:0] expand(
    input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0] rc;
    logic [14:0][127:0] rk;
    int nr;
    nr = nk + 6;
    rc = 8'h01;
    rk = '0;
    for (int i = 0; i < 60; i++) w[i] = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xtime(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++)
      rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return rk;
  endfunction

  task automatic set_key(input int k, input logic [255:0] key,
                         input int nk);
    logic [14:0][127:0] f;
    f = expand(key, nk);
    case (k)
      0: rk128 = f[10:0];
      1: rk192 = f[12:0];
      2: rk256 = f;
      default: rk128u2 = f[10:0];
    endcase
  endtask

  // one block from IDLE: check latency, busy, data and tag
  task automatic run_one(input int k, input logic [127:0] p,
                         input logic [7:0] tg,
                         input logic [127:0] exp, input int lat,
                         input string nm);
    int n;
    @(negedge clk);
    chk({nm, " ready_idle"}, 160'(rdy[k]), 160'(1));
    vin[k] = 1'b1;
    pt = p;
    tag = tg;
    @(posedge clk);
    #1;
    vin[k] = 1'b0;
    chk({nm, " busy"}, 160'(bsy[k]), 160'(1));
    n = 0;
    while (!vout[k] && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({nm, " latency"}, 160'(n), 160'(lat));
    chk({nm, " ct"}, 160'(cto[k]), 160'(exp));
    chk({nm, " tag"}, 160'(tgo[k]), 160'(tg));
    @(posedge clk);
    #1;
    chk({nm, " idle"}, 160'({vout[k], bsy[k]}), 160'(0));
  endtask

  typedef struct {
    int dut;
    logic [255:0] key;
    int nk;
    logic [127:0] p;
    logic [127:0] c;
    int lat;
    string nm;
  } vec_t;

  localparam logic [255:0] K128 =
    {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KB =
    {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] PT1 =
    128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT1 =
    128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  vec_t vec [6];
  logic [127:0] bp [5];
  logic [127:0] bc [5];
  time acc [5];

  initial begin
    int n;
    logic stale;
    vec[0] = '{0, K128, 4, PT1, CT1, 10, "c1_128"};
    vec[1] = '{0, KB, 4, 128'h3243f6a8885a308d313198a2e0370734,
               128'h3925841d02dc09fbdc118597196a0b32, 10, "appb_128"};
    vec[2] = '{0, 256'h0, 4, 128'h0,
               128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 10, "zero_128"};
    vec[3] = '{1, {192'h000102030405060708090a0b0c0d0e0f1011121314151617,
                   64'h0}, 6, PT1,
               128'hdda97ca4864cdfe06eaf70a0ec0d7191, 12, "c2_192"};
    vec[4] = '{2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
               8, PT1, 128'h8ea2b7ca516745bfeafc49904b496089, 14, "c3_256"};
    vec[5] = '{3, KB, 4, 128'h3243f6a8885a308d313198a2e0370734,
               128'h3925841d02dc09fbdc118597196a0b32, 5, "appb_u2"};

    bp[0] = 128'h3243f6a8885a308d313198a2e0370734;
    bc[0] = 128'h3925841d02dc09fbdc118597196a0b32;
    bp[1] = 128'h6bc1bee22e409f96e93d7e117393172a;
    bc[1] = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    bp[2] = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    bc[2] = 128'hf5d3d58503b9699de785895a96fdbaaf;
    bp[3] = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
    bc[3] = 128'h43b1cd7f598ece23881b00e3ed030688;
    bp[4] = 128'hf69f2445df4f9b17ad2b417be66c3710;
    bc[4] = 128'h7b0c785e27e8ad3f8223207104725dd4;

    rst_n = 1'b0;
    ready_i = 1'b1;
    pt = '0;
    tag = '0;
    for (int k = 0; k < 4; k++) vin[k] = 1'b0;
    rk128 = '0;
    rk192 = '0;
    rk256 = '0;
    rk128u2 = '0;
    #12;
    for (int k = 0; k < 4; k++)
      chk($sformatf("reset_d%0d", k),
          160'({vout[k], bsy[k], rdy[k], tgo[k], cto[k]}),
          160'({1'b0, 1'b0, 1'b1, 8'h0, 128'h0}));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      set_key(vec[i].dut, vec[i].key, vec[i].nk);
      run_one(vec[i].dut, vec[i].p, 8'(8'h10 + i), vec[i].c,
              vec[i].lat, vec[i].nm);
    end

    // five back-to-back blocks, sink always ready
    set_key(0, KB, 4);
    @(negedge clk);
    vin[0] = 1'b1;
    pt = bp[0];
    tag = 8'd0;
    for (int b = 0; b < 5; b++) begin
      n = 0;
      while (!rdy[0] && n < 40) begin
        @(negedge clk);
        n++;
      end
      @(posedge clk);
      acc[b] = $time;
      #1;
      if (b < 4) begin
        pt = bp[b+1];
        tag = 8'(b + 1);
      end else begin
        vin[0] = 1'b0;
      end
      n = 0;
      while (!vout[0] && n < 40) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk($sformatf("b2b_ct%0d", b), 160'(cto[0]), 160'(bc[b]));
      chk($sformatf("b2b_tag%0d", b), 160'(tgo[0]), 160'(b));
      if (b > 0)
        chk($sformatf("b2b_gap%0d", b), 160'(acc[b] - acc[b-1]),
            160'(110));
    end
    @(posedge clk);
    #1;

    // output backpressure for 7 clocks, next block waiting
    set_key(0, K128, 4);
    @(negedge clk);
    ready_i = 1'b0;
    vin[0] = 1'b1;
    pt = PT1;
    tag = 8'h55;
    @(posedge clk);
    #1;
    tag = 8'h66;
    n = 0;
    while (!vout[0] && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("bp_latency", 160'(n), 160'(10));
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d", c),
          160'({vout[0], rdy[0], tgo[0], cto[0]}),
          160'({1'b1, 1'b0, 8'h55, CT1}));
    end
    ready_i = 1'b1;
    #1;
    chk("bp_ready_rel", 160'(rdy[0]), 160'(1));
    @(posedge clk);
    #1;
    vin[0] = 1'b0;
    chk("bp_next_run", 160'({vout[0], bsy[0]}), 160'({1'b0, 1'b1}));
    n = 0;
    while (!vout[0] && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("bp_next_lat", 160'(n), 160'(10));
    chk("bp_next_out", 160'({tgo[0], cto[0]}), 160'({8'h66, CT1}));
    @(posedge clk);
    #1;

    // reset pulse in the middle of a block
    @(negedge clk);
    vin[0] = 1'b1;
    pt = PT1;
    tag = 8'h77;
    @(posedge clk);
    #1;
    vin[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out", 160'({vout[0], bsy[0], tgo[0], cto[0]}),
        160'(0));
    @(negedge clk);
    rst_n = 1'b1;
    stale = 1'b0;
    for (int c = 0; c < 15; c++) begin
      pt = 128'(c * 32'h01010101);
      @(negedge clk);
      stale = stale | vout[0] | bsy[0];
    end
    chk("rst_no_stale", 160'(stale), 160'(0));
    run_one(0, PT1, 8'h88, CT1, 10, "post_rst");

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
